mem_arbiter: RTL

//  Two-master arbiter sharing the single mmio/memory port between instruction fetch (IF) and load/store (D).

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (IF, D) and the shared mmio slave port.
// The master modport is the arbiter's view; slave is the view of the CPU side plus the slave.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int BW = DW / 8;

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic          if_err;
   logic [DW-1:0] if_rdata;

   logic          d_req;
   logic          d_we;
   logic [BW-1:0] d_be;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic          d_err;
   logic [DW-1:0] d_rdata;

   logic          m_req;
   logic          m_we;
   logic [BW-1:0] m_be;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_ack;
   logic [DW-1:0] m_rdata;

   logic          grant;
   logic          busy;

   modport master (
      input  if_req, if_addr,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      input  m_ack, m_rdata,
      output if_ack, if_err, if_rdata,
      output d_ack, d_err, d_rdata,
      output m_req, m_we, m_be, m_addr, m_wdata,
      output grant, busy
   );

   modport slave (
      output if_req, if_addr,
      output d_req, d_we, d_be, d_addr, d_wdata,
      output m_ack, m_rdata,
      input  if_ack, if_err, if_rdata,
      input  d_ack, d_err, d_rdata,
      input  m_req, m_we, m_be, m_addr, m_wdata,
      input  grant, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mmio port between instruction fetch and load/store,
// one transaction in flight, with a watchdog that turns a hung slave access into an error ack.
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic         CLK100MHZ,
   input  logic         CPU_RESETN,
   mem_arbiter_if.master bus
);
   localparam int BW  = DW / 8;
   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state_q, state_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic          last_grant_q, last_grant_d;
   logic          grant_q, grant_d;
   logic          busy_q, busy_d;

   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [BW-1:0] m_be_q, m_be_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;

   logic          if_ack_q, if_ack_d;
   logic          if_err_q, if_err_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic          d_ack_q, d_ack_d;
   logic          d_err_q, d_err_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;

   logic any_req, pick_d, ack_evt, to_evt;

   // On contention the side that did not win last time goes next.
   assign any_req = bus.if_req | bus.d_req;
   assign pick_d  = bus.d_req & (~bus.if_req | ~last_grant_q);
   assign ack_evt = (state_q == BUSY) & bus.m_ack;
   assign to_evt  = (state_q == BUSY) & ~bus.m_ack & (wd_q == WDW'(TIMEOUT - 1));

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q      <= IDLE;
         wd_q         <= '0;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         busy_q       <= 1'b0;
         m_req_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_be_q       <= '0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         if_ack_q     <= 1'b0;
         if_err_q     <= 1'b0;
         if_rdata_q   <= '0;
         d_ack_q      <= 1'b0;
         d_err_q      <= 1'b0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         wd_q         <= wd_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         m_req_q      <= m_req_d;
         m_we_q       <= m_we_d;
         m_be_q       <= m_be_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         if_ack_q     <= if_ack_d;
         if_err_q     <= if_err_d;
         if_rdata_q   <= if_rdata_d;
         d_ack_q      <= d_ack_d;
         d_err_q      <= d_err_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = BUSY;
         BUSY:    if (ack_evt || to_evt) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; acks and errs are single-cycle pulses by default.
   always_comb begin
      wd_d         = wd_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      busy_d       = busy_q;
      m_req_d      = m_req_q;
      m_we_d       = m_we_q;
      m_be_d       = m_be_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      if_ack_d     = 1'b0;
      if_err_d     = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_ack_d      = 1'b0;
      d_err_d      = 1'b0;
      d_rdata_d    = d_rdata_q;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               m_req_d      = 1'b1;
               busy_d       = 1'b1;
               wd_d         = '0;
               grant_d      = pick_d;
               last_grant_d = pick_d;
               if (pick_d) begin
                  m_we_d    = bus.d_we;
                  m_be_d    = bus.d_be;
                  m_addr_d  = bus.d_addr;
                  m_wdata_d = bus.d_wdata;
               end else begin
                  m_we_d    = 1'b0;
                  m_be_d    = '1;
                  m_addr_d  = bus.if_addr;
                  m_wdata_d = '0;
               end
            end
         end
         BUSY: begin
            wd_d = wd_q + 1'b1;
            if (ack_evt) begin
               m_req_d = 1'b0;
               if (grant_q) begin
                  d_ack_d = 1'b1;
                  if (!m_we_q) d_rdata_d = bus.m_rdata;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bus.m_rdata;
               end
            end else if (to_evt) begin
               m_req_d = 1'b0;
               if (grant_q) begin
                  d_ack_d   = 1'b1;
                  d_err_d   = 1'b1;
                  d_rdata_d = '0;
               end else begin
                  if_ack_d   = 1'b1;
                  if_err_d   = 1'b1;
                  if_rdata_d = '0;
               end
            end
         end
         RESP: busy_d = 1'b0;
         default: busy_d = 1'b0;
      endcase
   end

   assign bus.m_req    = m_req_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_be     = m_be_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.if_ack   = if_ack_q;
   assign bus.if_err   = if_err_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_ack    = d_ack_q;
   assign bus.d_err    = d_err_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.grant    = grant_q;
   assign bus.busy     = busy_q;
endmodule
